pc_unit: RTL and testbench

- Instruction-fetch and program-counter stage directly upstream of the instruction decoder.
- Holds the PC and fetches 16-bit program words: [15:8] opcode, [7:0] immediate/target.
- Presents the opcode to the decoder and consumes the decoder's jmp_en, stack_control and rst outputs.
- Owns the hardware return-address stack and produces stack_flags for the decoder.

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_unit_ret_stack.sv | 46 ++++
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared fetch/decode constants: opcodes and the decoder's stack_control encoding.
package pc_unit_pkg;

    localparam logic [7:0] OP_CLL = 8'h0C;
    localparam logic [7:0] OP_RET = 8'h0D;
    localparam logic [7:0] OP_NOP = 8'h11;

    typedef enum logic [1:0] {
        SC_NONE = 2'b00,
        SC_POP  = 2'b01,
        SC_PUSH = 2'b10,
        SC_ILL  = 2'b11
    } stack_ctl_e;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO. Guards its own overflow/underflow; flush empties it in one cycle.
module pc_unit_ret_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_full,
    output logic            o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    logic [AW:0]     r_sp;
    logic [PC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   w_top_idx;

    assign o_full    = (r_sp == SP_FULL);
    assign o_empty   = (r_sp == '0);
    assign w_top_idx = r_sp[AW-1:0] - AW'(1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sp <= '0;
        else if (i_flush)
            r_sp <= '0;
        else if (i_push && !o_full)
            r_sp <= r_sp + (AW+1)'(1);
        else if (i_pop && !o_empty)
            r_sp <= r_sp - (AW+1)'(1);
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_flush)
            r_mem[r_sp[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch/PC stage: two-state FETCH/EXEC loop feeding the decoder, plus the return stack.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_soft_rst,
    input  logic            i_jmp_en,
    input  logic [1:0]      i_stack_control,
    output logic [1:0]      o_stack_flags,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic [15:0]     i_imem_rdata,
    input  logic            i_imem_valid,
    output logic [7:0]      o_instr,
    output logic [7:0]      o_imm,
    output logic [PC_W-1:0] o_pc,
    output logic            o_stk_err
);

    localparam logic S_FETCH = 1'b0;
    localparam logic S_EXEC  = 1'b1;

    logic            r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_imm;
    logic            r_stk_err;

    logic            w_full, w_empty;
    logic            w_push, w_pop, w_flush;
    logic [PC_W-1:0] w_top, w_pc_inc, w_target, w_pc_nxt;
    logic            w_err_nxt;
    stack_ctl_e      w_sc;

    assign w_pc_inc      = r_pc + PC_W'(1);
    assign w_target      = PC_W'(r_imm);
    assign w_sc          = stack_ctl_e'(i_stack_control);

    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_imm         = r_imm;
    assign o_instr       = (r_state == S_EXEC) ? r_ir : OP_NOP;
    assign o_stk_err     = r_stk_err;
    assign o_stack_flags = {w_full, w_empty};

    always_comb begin
        w_pc_nxt  = r_pc;
        w_err_nxt = r_stk_err;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        if (i_soft_rst) begin
            w_flush   = 1'b1;
            w_pc_nxt  = '0;
            w_err_nxt = 1'b0;
        end else if (r_state == S_EXEC) begin
            w_pc_nxt = w_pc_inc;
            // Decoder withheld push/pop at a boundary: still flag the misuse.
            if ((r_ir == OP_CLL && w_full) || (r_ir == OP_RET && w_empty))
                w_err_nxt = 1'b1;
            case (w_sc)
                SC_ILL: w_err_nxt = 1'b1;
                SC_POP: begin
                    if (w_empty) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                end
                SC_PUSH: begin
                    if (i_jmp_en) begin
                        w_pc_nxt = w_target;
                        if (w_full) w_err_nxt = 1'b1;
                        else        w_push    = 1'b1;
                    end
                end
                default: begin
                    if (i_jmp_en) w_pc_nxt = w_target;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= OP_NOP;
            r_imm     <= '0;
            r_stk_err <= 1'b0;
        end else begin
            r_pc      <= w_pc_nxt;
            r_stk_err <= w_err_nxt;
            if (i_soft_rst) begin
                r_state <= S_FETCH;
                r_ir    <= OP_NOP;
                r_imm   <= '0;
            end else if (r_state == S_FETCH) begin
                if (i_imem_valid) begin
                    r_ir    <= i_imem_rdata[15:8];
                    r_imm   <= i_imem_rdata[7:0];
                    r_state <= S_EXEC;
                end
            end else begin
                r_state <= S_FETCH;
            end
        end
    end

    pc_unit_ret_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_ret_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_pc_inc),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed plan plus random decoder traffic against a queue-based model.
module tb_pc_unit;

    localparam int PC_W  = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            soft_rst = 1'b0, jmp_en = 1'b0, imem_valid = 1'b0;
    logic [1:0]      stack_control = 2'b00;
    logic [15:0]     imem_rdata = '0;
    logic [1:0]      stack_flags;
    logic [PC_W-1:0] imem_addr, pc;
    logic [7:0]      instr, imm;
    logic            stk_err;

    pc_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_soft_rst      (soft_rst),
        .i_jmp_en        (jmp_en),
        .i_stack_control (stack_control),
        .o_stack_flags   (stack_flags),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .i_imem_valid    (imem_valid),
        .o_instr         (instr),
        .o_imm           (imm),
        .o_pc            (pc),
        .o_stk_err       (stk_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: the stack is a plain queue of return addresses.
    int       m_pc;
    bit       m_exec;
    bit [7:0] m_ir, m_imm;
    bit       m_err;
    int       m_stk[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_exec = 0; m_ir = 8'h11; m_imm = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        int n, nxt;
        n = m_stk.size();
        if (!rst_n || soft_rst) begin
            model_reset();
            return;
        end
        if (!m_exec) begin
            if (imem_valid) begin
                m_ir = imem_rdata[15:8]; m_imm = imem_rdata[7:0]; m_exec = 1;
            end
            return;
        end
        m_exec = 0;
        nxt = (m_pc + 1) % (1 << PC_W);
        if ((m_ir == 8'h0C && n == DEPTH) || (m_ir == 8'h0D && n == 0)) m_err = 1;
        if (stack_control == 2'b11) begin
            m_err = 1; m_pc = nxt;
        end else if (stack_control == 2'b01) begin
            if (n == 0) begin m_err = 1; m_pc = nxt; end
            else m_pc = m_stk.pop_back();
        end else if (stack_control == 2'b10 && jmp_en) begin
            if (n == DEPTH) m_err = 1;
            else m_stk.push_back(nxt);
            m_pc = m_imm;
        end else if (jmp_en) begin
            m_pc = m_imm;
        end else begin
            m_pc = nxt;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",        16'(pc),          16'(m_pc));
            check("imem_addr", 16'(imem_addr),   16'(m_pc));
            check("instr",     16'(instr),       16'(m_exec ? m_ir : 8'h11));
            check("imm",       16'(imm),         16'(m_imm));
            check("stk_err",   16'(stk_err),     16'(m_err));
            check("flags",     16'(stack_flags), 16'({m_stk.size() == DEPTH, m_stk.size() == 0}));
        end
    end

    task automatic cyc(input bit v, input logic [15:0] w, input bit s, input bit j, input logic [1:0] sc);
        imem_valid = v; imem_rdata = w; soft_rst = s; jmp_en = j; stack_control = sc;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic ins(input logic [15:0] w, input bit j, input logic [1:0] sc);
        cyc(1'b1, w, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 16'h0000, 1'b0, j, sc);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",    16'(pc), 16'h0000);
        check("rst_flags", 16'(stack_flags), 16'h0001);
        check("rst_instr", 16'(instr), 16'h0011);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Plain sequential fetch: pc 0 -> 1 -> 2, opcode visible only in EXEC.
        cyc(1'b1, 16'h0533, 1'b0, 1'b0, 2'b00);
        check("exec_instr", 16'(instr), 16'h0005);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        ins(16'h1100, 1'b0, 2'b00);
        check("seq_pc", 16'(pc), 16'h0002);
        ins(16'h0500, 1'b0, 2'b00);
        ins(16'h0500, 1'b0, 2'b00);

        // Stall at pc=4.
        repeat (3) cyc(1'b0, 16'h0777, 1'b0, 1'b1, 2'b10);
        check("stall_addr", 16'(imem_addr), 16'h0004);
        check("stall_instr", 16'(instr), 16'h0011);
        ins(16'h0A5A, 1'b0, 2'b00);

        // Call from 0x10 to 0x40, then return to 0x11.
        ins(16'h0110, 1'b1, 2'b00);
        ins(16'h0C40, 1'b1, 2'b10);
        check("call_pc", 16'(pc), 16'h0040);
        check("call_flags", 16'(stack_flags), 16'h0000);
        ins(16'h0D00, 1'b0, 2'b01);
        check("ret_pc", 16'(pc), 16'h0011);

        // DEPTH+1 nested calls from pc=0, then unwind.
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < DEPTH; i++) ins({8'h0C, 8'(8'h20 + 8 * i)}, 1'b1, 2'b10);
        check("full_flags", 16'(stack_flags), 16'h0002);
        ins(16'h0C80, 1'b1, 2'b00);
        check("ovf_pc", 16'(pc), 16'h0080);
        check("ovf_err", 16'(stk_err), 16'h0001);
        ins(16'h0D00, 1'b0, 2'b01);
        check("unwind_first", 16'(pc), 16'h0051);
        for (int i = 1; i < DEPTH; i++) ins(16'h0D00, 1'b0, 2'b01);
        check("unwind_last", 16'(pc), 16'h0001);

        // Return at empty falls back to imm.
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 2'b00);
        ins(16'h0133, 1'b1, 2'b00);
        ins(16'h0D00, 1'b1, 2'b00);
        check("ret_empty_pc", 16'(pc), 16'h0000);
        check("ret_empty_err", 16'(stk_err), 16'h0001);

        // Wrap at 0xFF, both sequential and as a pushed return address.
        ins(16'h01FF, 1'b1, 2'b00);
        ins(16'h0500, 1'b0, 2'b00);
        check("wrap_pc", 16'(pc), 16'h0000);
        ins(16'h01FF, 1'b1, 2'b00);
        ins(16'h0C30, 1'b1, 2'b10);
        ins(16'h0D00, 1'b0, 2'b01);
        check("wrap_ret", 16'(pc), 16'h0000);

        // soft_rst during EXEC with three entries on the stack.
        for (int i = 0; i < 3; i++) ins(16'h0C60, 1'b1, 2'b10);
        cyc(1'b1, 16'h0511, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 2'b10);
        check("srst_pc", 16'(pc), 16'h0000);
        check("srst_flags", 16'(stack_flags), 16'h0001);
        check("srst_err", 16'(stk_err), 16'h0000);

        // rst_n pulse in the middle of a stall.
        ins(16'h0C90, 1'b1, 2'b10);
        ins(16'h0500, 1'b0, 2'b11);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_pc", 16'(pc), 16'h0000);
        check("arst_err", 16'(stk_err), 16'h0000);
        check("arst_flags", 16'(stack_flags), 16'h0001);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;

        // Random decoder/memory traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] op;
            logic [1:0] sc;
            int r;
            r = $urandom_range(0, 3);
            op = (r == 0) ? 8'h0C : (r == 1) ? 8'h0D : (r == 2) ? 8'h11 : 8'($urandom);
            r = $urandom_range(0, 19);
            sc = (r < 10) ? 2'b00 : (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
            cyc($urandom_range(0, 3) != 0, {op, 8'($urandom)},
                $urandom_range(0, 99) == 0, 1'($urandom), sc);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
